// File: rtl/ps2_crypt_link.sv
// ps2_crypt_link
//   PS/2 keyboard receiver with frame checking and timeout recovery. Each
//   accepted scan code is XOR-encrypted with a Fibonacci LFSR keystream,
//   buffered in a small FIFO and shifted out MSB first on the CPLD-AVR link.
//
// Ports
//   Clk         system clock (the only clock)
//   Reset       synchronous active-high reset
//   ps2_clk     raw PS/2 clock (asynchronous)
//   ps2_data    raw PS/2 data (asynchronous)
//   tx_ready    AVR can take a new byte (sampled only between bytes)
//   serial_clk  divided link clock
//   serial_out  link data, MSB first
//   sending     high during the 8 data bit periods
//   frame_err   one-Clk pulse on start/parity/stop/timeout error
//   overflow    one-Clk pulse when an accepted byte is dropped (FIFO full)
//   fifo_level  number of bytes currently buffered
//
// Build option
//   PS2_PARITY_CHECK_EN  when defined, frames must carry odd parity;
//                        otherwise the parity bit is captured and ignored.
module ps2_crypt_link #(
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hFFFF,
  parameter int                FIFO_DEPTH = 4,
  parameter int                CLK_DIV    = 250,
  parameter int                GAP_BITS   = 4,
  parameter int                TIMEOUT    = 4096
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          tx_ready,
  output logic                          serial_clk,
  output logic                          serial_out,
  output logic                          sending,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  // T_GAP is left one boundary early so T_IDLE can start the next byte
  // exactly GAP_BITS periods after the last data bit.
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS >= 2) ? GAP_BITS - 2 : 0);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAR, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_state_t;

  logic              clk_meta, clk_sync, clk_prev;
  logic              data_meta, data_sync;
  logic              ps2_edge;

  rx_state_t         rx_state, rx_next;
  logic [7:0]        rx_shift;
  logic [2:0]        rx_bits;
  logic              rx_par;
  logic [TW-1:0]     rx_timer;
  logic              timeout_hit, frame_ok, accept, rx_err;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty, push, ovf_now;
  logic [7:0]        fifo_head, enc_byte;
  logic [LFSR_W-1:0] lfsr;

  logic [DW-1:0]     div_cnt;
  logic              div_wrap, bit_tick;

  tx_state_t         tx_state, tx_next;
  logic [7:0]        tx_shift;
  logic [2:0]        tx_bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              tx_pop;

  // Two-flop synchronisers; the clock path idles high so reset never fakes an edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign ps2_edge    = clk_prev & ~clk_sync;
  assign timeout_hit = (rx_state != R_IDLE) && !ps2_edge && (rx_timer == TO_LAST);
  assign frame_ok    = data_sync & (!PARITY_CHECK || (^{rx_shift, rx_par}));

  // RX state register
  always_ff @(posedge Clk) begin
    if (Reset) rx_state <= R_IDLE;
    else       rx_state <= rx_next;
  end

  // RX next state; a timeout overrides whatever the frame was doing
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE: if (ps2_edge && !data_sync)      rx_next = R_DATA;
      R_DATA: if (ps2_edge && rx_bits == 3'd7) rx_next = R_PAR;
      R_PAR:  if (ps2_edge)                    rx_next = R_STOP;
      R_STOP: if (ps2_edge)                    rx_next = R_IDLE;
      default:                                 rx_next = R_IDLE;
    endcase
    if (timeout_hit) rx_next = R_IDLE;
  end

  // RX outputs: accept or reject at the stop-bit edge
  always_comb begin
    accept = (rx_state == R_STOP) && ps2_edge && frame_ok;
    rx_err = ((rx_state == R_STOP) && ps2_edge && !frame_ok) || timeout_hit;
  end

  // RX datapath: LSB-first shift, parity capture, inactivity timer
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_shift <= '0;
      rx_bits  <= '0;
      rx_par   <= 1'b0;
      rx_timer <= '0;
    end else begin
      if (rx_state == R_IDLE || ps2_edge) rx_timer <= '0;
      else                                rx_timer <= rx_timer + TW'(1);
      if (ps2_edge) begin
        case (rx_state)
          R_IDLE: rx_bits <= '0;
          R_DATA: begin
            rx_shift <= {data_sync, rx_shift[7:1]};
            rx_bits  <= rx_bits + 3'd1;
          end
          R_PAR:  rx_par <= data_sync;
          default: ;
        endcase
      end
    end
  end

  assign fifo_full  = (fifo_level == FIFO_FULL);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign enc_byte   = rx_shift ^ lfsr[7:0];
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign push       = accept && (!fifo_full || tx_pop);
  assign ovf_now    = accept && fifo_full && !tx_pop;

  // Error/overflow pulses
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= rx_err;
      overflow  <= ovf_now;
    end
  end

  // FIFO and keystream; the LFSR only advances when a byte is really stored
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= enc_byte;
        wr_ptr           <= wr_ptr + AW'(1);
        lfsr             <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
      end
      if (tx_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, tx_pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign div_wrap = (div_cnt == DIV_LAST);
  assign bit_tick = div_wrap & serial_clk;

  // Link clock divider; a bit boundary is the falling wrap of serial_clk
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt    <= '0;
      serial_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt    <= '0;
      serial_clk <= ~serial_clk;
    end else begin
      div_cnt    <= div_cnt + DW'(1);
    end
  end

  // TX state register
  always_ff @(posedge Clk) begin
    if (Reset) tx_state <= T_IDLE;
    else       tx_state <= tx_next;
  end

  // TX next state
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE: if (bit_tick && !fifo_empty && tx_ready) tx_next = T_SEND;
      T_SEND: if (bit_tick && tx_bit_cnt == 3'd7)
                tx_next = (GAP_BITS >= 2) ? T_GAP : T_IDLE;
      T_GAP:  if (bit_tick && gap_cnt == GAP_LAST)  tx_next = T_IDLE;
      default:                                      tx_next = T_IDLE;
    endcase
  end

  // TX outputs: pop decision (tx_ready only matters between bytes)
  always_comb begin
    tx_pop = (tx_state == T_IDLE) && bit_tick && !fifo_empty && tx_ready;
  end

  // TX datapath; serial_out and sending only move on bit boundaries
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tx_shift   <= '0;
      tx_bit_cnt <= '0;
      gap_cnt    <= '0;
      serial_out <= 1'b0;
      sending    <= 1'b0;
    end else if (bit_tick) begin
      case (tx_state)
        T_IDLE: if (tx_pop) begin
          tx_shift   <= fifo_head;
          serial_out <= fifo_head[7];
          sending    <= 1'b1;
          tx_bit_cnt <= '0;
        end
        T_SEND: begin
          if (tx_bit_cnt == 3'd7) begin
            sending    <= 1'b0;
            serial_out <= 1'b0;
            gap_cnt    <= '0;
          end else begin
            tx_shift   <= {tx_shift[6:0], 1'b0};
            serial_out <= tx_shift[6];
            tx_bit_cnt <= tx_bit_cnt + 3'd1;
          end
        end
        T_GAP:  gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_crypt_link.sv
// tb_ps2_crypt_link
//   Directed bench for ps2_crypt_link with a short link divider. Frames are
//   bit-banged on ps2_clk/ps2_data; transmitted bytes are sampled mid-bit.
//   Expected encrypted bytes are hand-computed from keys FF,FE,FC,F8,F0.
module tb_ps2_crypt_link;

  localparam int CLK_DIV  = 4;
  localparam int GAP_BITS = 4;
  localparam int TIMEOUT  = 4096;
  localparam int PERIOD   = 2 * CLK_DIV;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       tx_ready = 1'b1;
  logic       serial_clk, serial_out, sending, frame_err, overflow;
  logic [2:0] fifo_level;

  int totalCount = 0;
  int badCount   = 0;
  int errCount   = 0;
  int ovfCount   = 0;

  ps2_crypt_link #(
    .CLK_DIV (CLK_DIV),
    .GAP_BITS(GAP_BITS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .tx_ready  (tx_ready),
    .serial_clk(serial_clk),
    .serial_out(serial_out),
    .sending   (sending),
    .frame_err (frame_err),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  always #5 Clk = ~Clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge Clk) begin
    if (!Reset && frame_err) errCount <= errCount + 1;
    if (!Reset && overflow)  ovfCount <= ovfCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    totalCount++;
    if (got !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic resetDut();
    @(negedge Clk);
    Reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    waitCycles(3);
    Reset = 1'b0;
  endtask

  task automatic ps2Bit(input logic b);
    ps2_data = b;
    waitCycles(5);
    ps2_clk = 1'b0;
    waitCycles(10);
    ps2_clk = 1'b1;
    waitCycles(5);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop);
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(d[i]);
    ps2Bit(par);
    ps2Bit(stop);
    ps2_data = 1'b1;
  endtask

  // Waits for sending to rise, samples each bit mid-period, then the gap
  task automatic captureByte(input string tag, input logic [7:0] expByte);
    int waited = 0;
    logic [7:0] got = '0;
    while (sending !== 1'b1 && waited < 3000) begin
      @(negedge Clk);
      waited++;
    end
    checkOutput({tag, "_start"}, 32'(sending), 32'd1);
    if (sending === 1'b1) begin
      waitCycles(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
        got[7-i] = serial_out;
        checkOutput({tag, "_sending"}, 32'(sending), 32'd1);
        waitCycles(PERIOD);
      end
      for (int g = 0; g < GAP_BITS; g++) begin
        checkOutput({tag, "_gap_sending"}, 32'(sending), 32'd0);
        checkOutput({tag, "_gap_out"}, 32'(serial_out), 32'd0);
        if (g < GAP_BITS - 1) waitCycles(PERIOD);
      end
      checkOutput({tag, "_byte"}, 32'(got), 32'(expByte));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_sclk"}, 32'(serial_clk), 32'd0);
    checkOutput({tag, "_sout"}, 32'(serial_out), 32'd0);
    checkOutput({tag, "_sending"}, 32'(sending), 32'd0);
    checkOutput({tag, "_ferr"}, 32'(frame_err), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    int errBase;
    int ovfBase;
    int waited;
    logic [7:0] burst [6];
    burst[0] = 8'h1C; burst[1] = 8'h32; burst[2] = 8'h21;
    burst[3] = 8'h23; burst[4] = 8'h2B; burst[5] = 8'h34;

    // Reset values
    waitCycles(3);
    checkAllZero("reset");
    Reset = 1'b0;

    // First and second 0x1C frames: keys FF then FE
    fork
      applyStimulus(8'h1C, 1'b0, 1'b1);
      captureByte("first", 8'hE3);
    join
    checkOutput("first_level", 32'(fifo_level), 32'd0);
    fork
      applyStimulus(8'h1C, 1'b0, 1'b1);
      captureByte("second", 8'hE2);
    join

    // Bad parity frame, then bad stop frame
    resetDut();
    errBase = errCount;
`ifdef PS2_PARITY_CHECK_EN
    applyStimulus(8'h1C, 1'b1, 1'b1);
    waitCycles(5);
    checkOutput("par_err", 32'(errCount - errBase), 32'd1);
    checkOutput("par_level", 32'(fifo_level), 32'd0);
    fork
      applyStimulus(8'h1C, 1'b0, 1'b1);
      captureByte("par_after", 8'hE3);
    join
`else
    fork
      applyStimulus(8'h1C, 1'b1, 1'b1);
      captureByte("par_ignored", 8'hE3);
    join
    checkOutput("par_noerr", 32'(errCount - errBase), 32'd0);
`endif
    errBase = errCount;
    applyStimulus(8'h1C, 1'b0, 1'b0);
    waitCycles(5);
    checkOutput("stop_err", 32'(errCount - errBase), 32'd1);
    checkOutput("stop_level", 32'(fifo_level), 32'd0);
    fork
      applyStimulus(8'h1C, 1'b0, 1'b1);
      captureByte("stop_after", 8'hE2);
    join

    // Partial frame abandoned by the timeout
    resetDut();
    errBase = errCount;
    ps2Bit(1'b0);
    for (int i = 0; i < 4; i++) ps2Bit(1'b1);
    waitCycles(TIMEOUT + 50);
    checkOutput("timeout_err", 32'(errCount - errBase), 32'd1);
    fork
      applyStimulus(8'h1C, 1'b0, 1'b1);
      captureByte("timeout_after", 8'hE3);
    join
    checkOutput("timeout_noerr", 32'(errCount - errBase), 32'd1);

    // Flow control and overflow
    resetDut();
    tx_ready = 1'b0;
    errBase  = errCount;
    ovfBase  = ovfCount;
    for (int i = 0; i < 6; i++) applyStimulus(burst[i], ~^burst[i], 1'b1);
    waitCycles(20);
    checkOutput("full_level", 32'(fifo_level), 32'd4);
    checkOutput("full_ovf", 32'(ovfCount - ovfBase), 32'd2);
    checkOutput("full_noerr", 32'(errCount - errBase), 32'd0);
    checkOutput("full_idle", 32'(sending), 32'd0);
    tx_ready = 1'b1;
    captureByte("drain0", 8'hE3);
    captureByte("drain1", 8'hCC);
    captureByte("drain2", 8'hDD);
    captureByte("drain3", 8'hDB);
    checkOutput("drain_level", 32'(fifo_level), 32'd0);
    fork
      applyStimulus(8'h1C, 1'b0, 1'b1);
      captureByte("drain_next", 8'hEC);
    join

    // Reset in the middle of a byte
    resetDut();
    applyStimulus(8'h1C, 1'b0, 1'b1);
    waited = 0;
    while (sending !== 1'b1 && waited < 3000) begin
      @(negedge Clk);
      waited++;
    end
    checkOutput("midrst_started", 32'(sending), 32'd1);
    waitCycles(3 * PERIOD);
    Reset = 1'b1;
    @(negedge Clk);
    checkAllZero("midrst");
    waitCycles(2);
    Reset = 1'b0;
    fork
      applyStimulus(8'h1C, 1'b0, 1'b1);
      captureByte("midrst_after", 8'hE3);
    join

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
